// File: rtl/freq_channel_scheduler_if.sv
// Board-side and counter-side signals of the channel scheduler.
// The master side drives the raw inputs and configuration, and the slave
// side (the scheduler) drives the frequency counter controls and status.
interface freq_channel_scheduler_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BITS     = 12,
    parameter int unsigned CH_BITS  = $clog2(CHANNELS)
);
    logic [CHANNELS-1:0] signals;
    logic [CHANNELS-1:0] enable_mask;
    logic [15:0]         dwell_cycles;
    logic                cfg_we;
    logic [CH_BITS-1:0]  cfg_channel;
    logic [BITS-1:0]     cfg_period;
    logic                counter_reset;
    logic [BITS-1:0]     counter_period;
    logic                counter_period_load;
    logic                counter_signal;
    logic [CH_BITS-1:0]  channel;
    logic                channel_valid;

    modport master (
        output signals, enable_mask, dwell_cycles, cfg_we, cfg_channel, cfg_period,
        input  counter_reset, counter_period, counter_period_load, counter_signal,
               channel, channel_valid
    );

    modport slave (
        input  signals, enable_mask, dwell_cycles, cfg_we, cfg_channel, cfg_period,
        output counter_reset, counter_period, counter_period_load, counter_signal,
               channel, channel_valid
    );
endinterface

// File: rtl/freq_channel_scheduler.sv
// Round-robin time-sharing of one frequency counter among several inputs.
// Each visit is NEXT, RST, LOAD, then D cycles of DWELL on the selected channel.
module freq_channel_scheduler #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned BITS           = 12,
    parameter int unsigned DEFAULT_PERIOD = 1200,
    parameter int unsigned CH_BITS        = $clog2(CHANNELS)
) (
    input logic                      clk,
    input logic                      reset,
    freq_channel_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StNext, StRst, StLoad, StDwell} state_e;

    state_e             state_q, state_d;
    logic [CH_BITS-1:0] channel_q, channel_d;
    logic [15:0]        dwell_q, dwell_d;
    logic [BITS-1:0]    period_q [CHANNELS];
    logic [BITS-1:0]    period_d [CHANNELS];
    logic               counter_reset_q, counter_reset_d;
    logic               period_load_q, period_load_d;
    logic [BITS-1:0]    counter_period_q, counter_period_d;
    logic               valid_q, valid_d;

    logic [CH_BITS-1:0] next_ch;
    logic [CH_BITS-1:0] cand;
    logic               found;
    logic               any_en;

    assign any_en = |bus.enable_mask;

    // Lowest enabled index strictly above the current channel, wrapping; falls
    // back to the current channel itself at the last step of the search.
    always_comb begin
        next_ch = channel_q;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand = CH_BITS'((32'(channel_q) + k) % CHANNELS);
            if (!found && bus.enable_mask[cand]) begin
                found   = 1'b1;
                next_ch = cand;
            end
        end
    end

    // Period register file: writable in any state, out-of-range indices dropped.
    always_comb begin
        period_d = period_q;
        if (bus.cfg_we && (32'(bus.cfg_channel) < CHANNELS)) begin
            period_d[bus.cfg_channel] = bus.cfg_period;
        end
    end

    // Next-state logic for the visit sequence.
    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        dwell_d   = dwell_q;
        case (state_q)
            StIdle: begin
                if (any_en) state_d = StNext;
            end
            StNext: begin
                if (!any_en) begin
                    state_d = StIdle;
                end else begin
                    state_d   = StRst;
                    channel_d = next_ch;
                end
            end
            StRst: state_d = StLoad;
            StLoad: begin
                state_d = StDwell;
                dwell_d = (bus.dwell_cycles == 16'd0) ? 16'd1 : bus.dwell_cycles;
            end
            StDwell: begin
                // A disabled channel abandons the rest of its dwell.
                if (!bus.enable_mask[channel_q] || dwell_q <= 16'd1) begin
                    state_d = StNext;
                end else begin
                    dwell_d = dwell_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        counter_reset_d  = (state_d == StIdle) || (state_d == StRst);
        period_load_d    = (state_d == StLoad);
        valid_d          = (state_d == StDwell);
        counter_period_d = period_q[channel_d];
        if (state_d == StIdle) begin
            counter_period_d = '0;
        end else if (state_d == StDwell) begin
            // Hold the loaded value so mid-dwell writes wait for the next visit.
            counter_period_d = counter_period_q;
        end
    end

    // State, configuration and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            channel_q        <= '0;
            dwell_q          <= '0;
            counter_reset_q  <= 1'b1;
            period_load_q    <= 1'b0;
            counter_period_q <= '0;
            valid_q          <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                period_q[i] <= BITS'(DEFAULT_PERIOD);
            end
        end else begin
            state_q          <= state_d;
            channel_q        <= channel_d;
            dwell_q          <= dwell_d;
            counter_reset_q  <= counter_reset_d;
            period_load_q    <= period_load_d;
            counter_period_q <= counter_period_d;
            valid_q          <= valid_d;
            period_q         <= period_d;
        end
    end

    assign bus.counter_reset       = counter_reset_q;
    assign bus.counter_period_load = period_load_q;
    assign bus.counter_period      = counter_period_q;
    assign bus.channel             = channel_q;
    assign bus.channel_valid       = valid_q;
    assign bus.counter_signal      = bus.signals[channel_q] & valid_q;

endmodule
